multiport_register_bank: RTL and testbench

//   Parametrised successor to the single-port register file: one write port and
//   NUM_RD independent read ports over a 2**ADDR_DEPTH x DATA_WIDTH store.

---
 rtl/multiport_register_bank.sv | 155 +++++++++++++++
 tb/tb_multiport_register_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_bank.sv
// Register bank with one write port and NUM_RD independent read ports.
// A hardware sweep writes INIT_VALUE everywhere after reset or clear; reads have 1 or 2 cycles of latency.
module multiport_register_bank #(
    parameter int unsigned            DATA_WIDTH = 24,
    parameter int unsigned            ADDR_DEPTH = 12,
    parameter int unsigned            NUM_RD     = 2,
    parameter int unsigned            RD_LATENCY = 1,
    parameter int unsigned            BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         clear,
    output logic                         ready,
    input  logic                         wr_en,
    input  logic [ADDR_DEPTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_DEPTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid
);

    localparam int unsigned DEPTH = 2 ** ADDR_DEPTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_DEPTH-1:0]   cnt;
    logic [ADDR_DEPTH-1:0]   cnt_next;

    logic                    mem_we;
    logic [ADDR_DEPTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_accept;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] s1_data;
    logic [NUM_RD-1:0]                 s1_valid;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            INIT: begin
                cnt_next = cnt + ADDR_DEPTH'(1);
                if (cnt == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // A write coinciding with clear is dropped; the sweep would overwrite it anyway.
    always_comb begin
        ready     = 1'b0;
        wr_accept = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = INIT_VALUE;
        unique case (state)
            INIT: begin
                mem_we = 1'b1;
            end
            RUN: begin
                ready     = 1'b1;
                wr_accept = wr_en && !clear;
                mem_we    = wr_accept;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_word[p] = mem[rd_addr[p*ADDR_DEPTH +: ADDR_DEPTH]];
            if ((BYPASS != 0) && wr_accept && (wr_addr == rd_addr[p*ADDR_DEPTH +: ADDR_DEPTH])) begin
                rd_word[p] = wr_data;
            end
        end
    end

    // Data registers only load on a delivered read so outputs hold between reads.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= '0;
            s1_data  <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                s1_valid[p] <= ready && rd_en[p];
                if (ready && rd_en[p]) begin
                    s1_data[p] <= rd_word[p];
                end
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [NUM_RD-1:0][DATA_WIDTH-1:0] s2_data;
        logic [NUM_RD-1:0]                 s2_valid;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= '0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                for (int unsigned p = 0; p < NUM_RD; p++) begin
                    if (s1_valid[p]) begin
                        s2_data[p] <= s1_data[p];
                    end
                end
            end
        end

        assign rd_data  = s2_data;
        assign rd_valid = s2_valid;
    end else begin : g_lat1
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_multiport_register_bank.sv
// Drives two bank configurations (latency 1 + bypass, latency 2 + no bypass) with shared stimulus
// and compares both against a cycle-level behavioural model of the storage and read delivery.
module tb_multiport_register_bank;

    localparam int DW    = 24;
    localparam int AD    = 3;
    localparam int NR    = 2;
    localparam int DEPTH = 8;

    logic                clock = 1'b0;
    logic                rst_n = 1'b1;
    logic                clear;
    logic                wr_en;
    logic [AD-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NR-1:0]       rd_en;
    logic [NR*AD-1:0]    rd_addr;

    logic                ready_a, ready_b;
    logic [NR*DW-1:0]    rd_data_a, rd_data_b;
    logic [NR-1:0]       rd_valid_a, rd_valid_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left;
    logic [NR-1:0] mv_a, mv_b, pv;
    logic [DW-1:0] md_a [NR];
    logic [DW-1:0] md_b [NR];
    logic [DW-1:0] pd   [NR];

    always #5 clock = ~clock;

    multiport_register_bank #(
        .DATA_WIDTH(DW), .ADDR_DEPTH(AD), .NUM_RD(NR),
        .RD_LATENCY(1), .BYPASS(1), .INIT_VALUE(24'h000000)
    ) dut_a (
        .clock(clock), .rst_n(rst_n), .clear(clear), .ready(ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    multiport_register_bank #(
        .DATA_WIDTH(DW), .ADDR_DEPTH(AD), .NUM_RD(NR),
        .RD_LATENCY(2), .BYPASS(0), .INIT_VALUE(24'h000000)
    ) dut_b (
        .clock(clock), .rst_n(rst_n), .clear(clear), .ready(ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        mv_a = '0; mv_b = '0; pv = '0;
        for (int p = 0; p < NR; p++) begin
            md_a[p] = '0; md_b[p] = '0; pd[p] = '0;
        end
    endtask

    task automatic model_edge();
        logic          wr_ok;
        logic [AD-1:0] a;
        // latency-2 reads issued last edge arrive now
        mv_b = pv;
        for (int p = 0; p < NR; p++) if (pv[p]) md_b[p] = pd[p];
        pv   = '0;
        mv_a = '0;
        if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            wr_ok = wr_en && !clear;
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AD +: AD];
                    mv_a[p] = 1'b1;
                    md_a[p] = (wr_ok && wr_addr == a) ? wr_data : m_mem[a];
                    pv[p]   = 1'b1;
                    pd[p]   = m_mem[a];
                end
            end
            if (wr_ok) m_mem[wr_addr] = wr_data;
            if (clear) sweep_left = DEPTH;
        end
    endtask

    task automatic compare_all();
        check("ready_a", ready_a, sweep_left == 0);
        check("ready_b", ready_b, sweep_left == 0);
        check("valid_a", rd_valid_a, mv_a);
        check("valid_b", rd_valid_b, mv_b);
        for (int p = 0; p < NR; p++) begin
            check("data_a", rd_data_a[p*DW +: DW], md_a[p]);
            check("data_b", rd_data_b[p*DW +: DW], md_b[p]);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (!ready_a && n < 40) begin
            cycle();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", ready_a, 0);
        check("rst_valid", {rd_valid_b, rd_valid_a}, 0);
        check("rst_data", {rd_data_b, rd_data_a}, 0);

        // 1: sweep length after reset, then every address reads zero
        @(negedge clock) rst_n = 1'b1;
        wait_ready("t1_sweep_len", 8);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 2'b11;
            rd_addr = {3'(7 - i), 3'(i)};
            cycle();
            check("t1_zero", rd_data_a, 0);
        end
        idle(); cycle(); cycle();

        // 2: both ports reading the same freshly written address
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'hABCDEF;
        cycle();
        idle(); rd_en = 2'b11; rd_addr = {3'd5, 3'd5};
        cycle();
        check("t2_valid_a", rd_valid_a, 2'b11);
        check("t2_data_a", rd_data_a, {24'hABCDEF, 24'hABCDEF});
        idle();
        cycle();
        check("t2_valid_b", rd_valid_b, 2'b11);
        check("t2_data_b", rd_data_b, {24'hABCDEF, 24'hABCDEF});
        cycle();

        // 3: same-cycle write and read of one address
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h123456;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
        cycle();
        check("t3_bypass", rd_data_a[DW-1:0], 24'h123456);
        idle();
        cycle();
        check("t3_nobypass", rd_data_b[DW-1:0], 24'h000000);
        cycle();

        // 4: fill, read just before clear, clear, then all zero
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 24'(16 + i);
            cycle();
        end
        idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
        cycle();
        check("t4_pre_a", rd_data_a[DW-1:0], 24'h000013);
        idle(); clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 24'hFFFFFF;
        cycle();
        check("t4_ready_low", ready_a, 0);
        check("t4_inflight_b", {rd_valid_b[0], rd_data_b[DW-1:0]}, {1'b1, 24'h000013});
        idle();
        wait_ready("t4_sweep_len", 8);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 2'b11;
            rd_addr = {3'(i), 3'(i)};
            cycle();
            check("t4_zero", rd_data_a, 0);
        end
        idle(); cycle(); cycle();

        // 5: reset in the middle of a sweep
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'hABCDEF;
        cycle();
        idle(); rd_en = 2'b11; rd_addr = {3'd5, 3'd5};
        cycle();
        idle(); cycle();
        clear = 1'b1;
        cycle();
        idle();
        repeat (4) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("t5_ready", {ready_b, ready_a}, 0);
        check("t5_valid", {rd_valid_b, rd_valid_a}, 0);
        check("t5_data", {rd_data_b, rd_data_a}, 0);
        model_reset();
        @(negedge clock) rst_n = 1'b1;
        wait_ready("t5_sweep_len", 8);

        // 6: random traffic against the model
        for (int k = 0; k < 1000; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom);
            wr_data = 24'($urandom);
            rd_en   = 2'($urandom);
            rd_addr = 6'($urandom);
            cycle();
        end
        idle(); cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
